// File: rtl/ucode_sequencer_if.sv
// Bus between the micro-sequencer, the instruction register and the external microcode ROM.
// The master side is the sequencer, which drives the ROM address and status flags.
interface ucode_sequencer_if #(
    parameter int IW  = 16,
    parameter int UAW = 8,
    parameter int UW  = 40
);
    logic [IW-1:0]  instr;
    logic [UW-1:0]  uword;
    logic           mem_ready;
    logic           resume;
    logic [UAW-1:0] uaddr;
    logic [3:0]     state;
    logic           mphase;
    logic           stall;
    logic           halted;

    modport master (
        input  instr, uword, mem_ready, resume,
        output uaddr, state, mphase, stall, halted
    );

    modport slave (
        output instr, uword, mem_ready, resume,
        input  uaddr, state, mphase, stall, halted
    );
endinterface

// File: rtl/ucode_sequencer.sv
// Machine-cycle sequencer and micro-ROM address generator with wait-state stalling and halt/resume.
// Define UCODE_SEQ_PERF_EN to add the retired_cnt / stall_cnt performance counters.
module ucode_sequencer #(
    parameter int              IW         = 16,
    parameter int              OPW        = 6,
    parameter int              UAW        = 8,
    parameter int              UW         = 40,
    parameter int              FETCH_ADDR = 2,
    parameter int              IDLE_ADDR  = 3,
    parameter int              READ_BASE  = 64,
    parameter int              EXEC_BASE  = 128,
    parameter logic [IW-1:0]   HALT_WORD  = 16'hfe00
) (
    input  logic                clk,
    input  logic                reset,
    ucode_sequencer_if.master   bus
`ifdef UCODE_SEQ_PERF_EN
    ,
    output logic [31:0]         retired_cnt,
    output logic [31:0]         stall_cnt
`endif
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_FETCHM  = 4'd2,
        S_DECODE  = 4'd3,
        S_DECODEM = 4'd4,
        S_READ    = 4'd5,
        S_READM   = 4'd6,
        S_EXEC    = 4'd7,
        S_EXECM   = 4'd8,
        S_HALT    = 4'd9
    } state_t;

    state_t         cur;
    state_t         nxt;
    logic [OPW-1:0] opcode;
    logic [31:0]    addr_wide;
    logic [1:0]     skip;
    logic           memwait;
    logic           mphase;
    logic           stall;
    logic           unused_bits;

    assign skip    = bus.uword[4:3];
    assign memwait = bus.uword[2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur <= S_IDLE;
        end else begin
            cur <= nxt;
        end
    end

    // Short opcodes live in the two bits below the format flag; long ones take OPW bits.
    always_comb begin
        opcode = '0;
        if (!bus.instr[IW-1]) begin
            opcode = {{(OPW-2){1'b0}}, bus.instr[IW-2:IW-3]};
        end else begin
            opcode = bus.instr[IW-2:IW-1-OPW];
        end
    end

    always_comb begin
        addr_wide = 32'(IDLE_ADDR);
        case (cur)
            S_FETCH, S_FETCHM:   addr_wide = 32'(FETCH_ADDR);
            S_DECODE, S_DECODEM: addr_wide = 32'(opcode);
            S_READ, S_READM:     addr_wide = 32'(opcode) + 32'(READ_BASE);
            S_EXEC, S_EXECM:     addr_wide = 32'(opcode) + 32'(EXEC_BASE);
            default:             addr_wide = 32'(IDLE_ADDR);
        endcase
    end

    assign mphase = (cur == S_FETCHM) || (cur == S_DECODEM) ||
                    (cur == S_READM)  || (cur == S_EXECM);
    assign stall  = mphase && memwait && !bus.mem_ready;

    // A stalled M phase simply keeps its state, which also freezes uaddr.
    always_comb begin
        nxt = cur;
        if (stall) begin
            nxt = cur;
        end else begin
            case (cur)
                S_IDLE:    nxt = S_FETCH;
                S_FETCH:   nxt = S_FETCHM;
                S_FETCHM:  nxt = S_DECODE;
                S_DECODE:  nxt = (bus.instr == HALT_WORD) ? S_HALT : S_DECODEM;
                S_DECODEM: begin
                    case (skip)
                        2'd0:    nxt = S_READ;
                        2'd1:    nxt = S_EXEC;
                        default: nxt = S_FETCH;
                    endcase
                end
                S_READ:    nxt = S_READM;
                S_READM:   nxt = S_EXEC;
                S_EXEC:    nxt = S_EXECM;
                S_EXECM:   nxt = S_FETCH;
                S_HALT:    nxt = bus.resume ? S_FETCH : S_HALT;
                default:   nxt = S_FETCH;
            endcase
        end
    end

    assign bus.uaddr  = addr_wide[UAW-1:0];
    assign bus.state  = cur;
    assign bus.mphase = mphase;
    assign bus.stall  = stall;
    assign bus.halted = (cur == S_HALT);

    assign unused_bits = ^{bus.uword[UW-1:5], bus.uword[1:0], addr_wide[31:UAW]};

`ifdef UCODE_SEQ_PERF_EN
    // Counters freeze in HALT, but the resume edge out of HALT still retires.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_cnt <= '0;
            stall_cnt   <= '0;
        end else if (cur == S_HALT) begin
            if (bus.resume) begin
                retired_cnt <= retired_cnt + 32'd1;
            end
        end else begin
            if (stall) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if ((nxt == S_FETCH) && ((cur == S_EXECM) || (cur == S_DECODEM))) begin
                retired_cnt <= retired_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/ucode_sequencer.md
Name: ucode_sequencer

Overview:
- Parametrised successor to the fixed 8-phase microcode decoder FSM.
- Owns the machine-cycle state register and the micro-ROM address generation.
- Adds over the previous generation:
  - configurable opcode, instruction and microword widths;
  - configurable ROM segment bases;
  - memory wait-state stalling;
  - a proper halt/resume state.
- Sits between the IR and the external microcode ROM; control-signal field decode stays downstream.

Parameters:
- IW, 16: instruction width.
- OPW, 6: long-opcode width; short opcode is fixed at 2 bits.
- UAW, 8: micro-ROM address width.
- UW, 40: microword width.
- FETCH_ADDR, 2: ROM address used in FETCH/FETCHM.
- IDLE_ADDR, 3: ROM address used in IDLE/HALT.
- READ_BASE, 64: ROM offset for READ/READM.
- EXEC_BASE, 128: ROM offset for EXEC/EXECM.
- HALT_WORD, 16'hfe00: instruction value that halts the machine.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr  in  IW  current IR contents.
- uword  in  UW  microword read at uaddr (combinational ROM).
- mem_ready  in  1  memory/peripheral ready for the current M phase.
- resume  in  1  leave HALT.
- uaddr  out  UAW  micro-ROM address.
- state  out  4  current state code.
- mphase  out  1  1 in M states (FETCHM, DECODEM, READM, EXECM).
- stall  out  1  M phase being held for mem_ready.
- halted  out  1  1 in HALT.

Behaviour:
- State codes:
  - IDLE=0, FETCH=1, FETCHM=2, DECODE=3, DECODEM=4, READ=5, READM=6, EXEC=7, EXECM=8, HALT=9.
  - mphase = (state is 2/4/6/8).
- Reset: while reset=0, state=IDLE (async), so stall=0, halted=0, uaddr=IDLE_ADDR. The first edge after release goes IDLE->FETCH.
- Opcode extraction:
  - If instr[IW-1]=0: opcode = instr[IW-2:IW-3], zero-extended to OPW.
  - Else: opcode = instr[IW-2:IW-1-OPW].
- uaddr (combinational, truncated to UAW):
  - FETCH/FETCHM: FETCH_ADDR.
  - DECODE/DECODEM: opcode.
  - READ/READM: opcode+READ_BASE.
  - EXEC/EXECM: opcode+EXEC_BASE.
  - IDLE/HALT/illegal codes: IDLE_ADDR.
- Microword fields used here:
  - skip = uword[4:3].
  - memwait = uword[2].
  - All other bits are ignored by this block.
- Transitions:
  - FETCH->FETCHM->DECODE.
  - DECODE->DECODEM, except DECODE with instr==HALT_WORD->HALT.
  - DECODEM by skip: skip=0->READ, 1->EXEC, 2->FETCH, 3->FETCH (reserved, treated as 2).
  - READ->READM->EXEC->EXECM->FETCH.
  - HALT stays in HALT while resume=0; resume=1 ->FETCH on the next edge.
  - Illegal state codes (10-15) ->FETCH.
- Stall:
  - In any M state with memwait=1 and mem_ready=0: state holds, stall=1, uaddr unchanged.
  - When mem_ready=1 is sampled, the normal transition occurs on that edge.
  - A stall has no timeout.
- Latency: the unstalled instruction is 8 cycles (full), 6 cycles (skip=1) or 4 cycles (skip=2).
- Priority: async reset > stall hold > halt detect > normal transition.
- HALT_WORD is checked only in DECODE; a value appearing elsewhere is ignored.
- Reset asserted mid-stall or mid-HALT goes to IDLE immediately.

Optional Feature:
- Macro: UCODE_SEQ_PERF_EN.
- When defined:
  - Adds output ports retired_cnt (32) and stall_cnt (32), both 0 on reset.
  - retired_cnt increments on every transition into FETCH from EXECM, from DECODEM (skip 2/3), or from HALT.
  - stall_cnt increments on every cycle with stall=1.
  - Both counters wrap modulo 2^32 and freeze while in HALT.
- When undefined: the ports and counters are absent; the rest of the behaviour is identical.

Test Plan:
- Reset release, short opcode instr=16'h4000, skip=0, memwait=0 -> states 1,2,3,4,5,6,7,8,1. uaddr: 2,2,2,2,66,66,130,130.
- Long opcode instr=16'h8c00 (opcode 6), DECODEM skip=1 -> DECODEM goes to EXEC, uaddr=134 for 2 cycles, then FETCH. The instruction takes 6 cycles.
- READM with memwait=1 and mem_ready low for 3 cycles -> state stays 6 for 4 cycles, stall=1 for 3 of them, EXEC on the cycle after mem_ready=1.
- instr=16'hfe00 reaching DECODE -> HALT (state 9, halted=1, uaddr=3) is held through 10 cycles of resume=0; a 1-cycle resume pulse ->FETCH.
- Reset driven low mid-stall in EXECM (async, between edges) -> state=0 immediately, stall=0. After release: IDLE then FETCH.
- With UCODE_SEQ_PERF_EN: 3 full instructions plus 2 stall cycles -> retired_cnt=3, stall_cnt=2. Counters hold across HALT.
